// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter
//   Round-robin arbiter that shares one active-low RGB LED among three
//   requesters. The winner's colour is shown for HOLD_CYCLES. An optional
//   LED-off gap of GAP_CYCLES follows, and then the arbiter returns to IDLE,
//   where it spends at least one cycle before it arbitrates again.
//
//   Optional feature macro: IDLE_BLINK_EN
//     When defined, the LED blinks off/white with a half-period of BLINK_HALF
//     while the arbiter is in IDLE with no request pending.
//
// Ports
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   req        in   3  level request per requester, held until its gnt bit
//   req_color  in   9  {G,B,R} colour of requester i at [3i+2:3i], active-high
//   gnt        out  3  one-cycle one-hot pulse when requester i wins
//   done       out  3  one-cycle one-hot pulse when requester i's display ends
//   busy       out  1  high while showing a colour or in the off gap
//   led        out  3  LED pins, active-low {G,B,R}; 3'b111 = off
module rgb_led_arbiter #(
  parameter int unsigned HOLD_CYCLES = 13_500_000,
  parameter int unsigned GAP_CYCLES  = 2_700_000,
  parameter int unsigned BLINK_HALF  = 13_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic [8:0] req_color,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       busy,
  output logic [2:0] led
);

  // One counter covers hold, gap and (optionally) blink timing.
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_HG > BLINK_HALF) ? MAX_HG : BLINK_HALF;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST  =
    CNT_W'((GAP_CYCLES > 32'd0) ? (GAP_CYCLES - 32'd1) : 32'd0);
`ifdef IDLE_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 32'd1);
`endif

  localparam logic [2:0] LED_OFF   = 3'b111;
  localparam logic [2:0] LED_WHITE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;   // most recent winner, drives rr order
  logic [2:0]       gnt_d, done_d, led_d;
  logic             busy_d;
  logic [1:0]       pick_w;
`ifdef IDLE_BLINK_EN
  logic             blink_q, blink_d; // 1 = white phase of the idle blink
`endif

  // Colour field of requester i.
  function automatic logic [2:0] color_of(input logic [8:0] c, input logic [1:0] i);
    case (i)
      2'd0:    return c[2:0];
      2'd1:    return c[5:3];
      default: return c[8:6];
    endcase
  endfunction

  // One-hot encoding of a requester index.
  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // First set request searching upward from the requester after 'last'.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    idx   = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;       // requester 0 searched first after reset
      gnt     <= 3'b000;
      done    <= 3'b000;
      busy    <= 1'b0;
      led     <= LED_OFF;
`ifdef IDLE_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      led     <= led_d;
`ifdef IDLE_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = 3'b000;
    done_d  = 3'b000;
    busy_d  = busy;
    led_d   = led;
    pick_w  = rr_pick(req, last_q);
`ifdef IDLE_BLINK_EN
    blink_d = blink_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (req != 3'b000) begin
          // Grant wins over any blink phase; the LED register latches the colour.
          gnt_d   = onehot(pick_w);
          led_d   = ~color_of(req_color, pick_w);
          busy_d  = 1'b1;
          cnt_d   = '0;
          last_d  = pick_w;
          state_d = ST_SHOW;
`ifdef IDLE_BLINK_EN
          blink_d = 1'b0;
`endif
        end else begin
`ifdef IDLE_BLINK_EN
          if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
            led_d   = blink_q ? LED_OFF : LED_WHITE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            led_d   = blink_q ? LED_WHITE : LED_OFF;
          end
`else
          led_d = LED_OFF;
`endif
        end
      end

      ST_SHOW: begin
        if (cnt_q == HOLD_LAST) begin
          done_d = onehot(last_q);
          led_d  = LED_OFF;
          cnt_d  = '0;
          if (GAP_CYCLES != 32'd0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
`ifdef IDLE_BLINK_EN
          blink_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        led_d = LED_OFF;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef IDLE_BLINK_EN
          blink_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        led_d   = LED_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter
//   Directed plus randomized bench for rgb_led_arbiter. dut_a has a two-cycle
//   gap and dut_b has no gap. Expected grants come from a round-robin model
//   over requester indices, and expected LED levels come from the display
//   timeline (hold, gap, idle).
module tb_rgb_led_arbiter;

  localparam int HOLD  = 4;
  localparam int GAP_A = 2;
  localparam int BLINK = 3;
`ifdef IDLE_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [2:0] req_a, req_b;
  logic [8:0] col_a, col_b;
  logic [2:0] gnt_a, done_a, led_a, gnt_b, done_b, led_b;
  logic       busy_a, busy_b;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic       sel_b  = 1'b0;
  int         last_w [2];
  int         idle_k;

  logic [2:0] obs_gnt, obs_done, obs_led;
  logic       obs_busy;
  assign obs_gnt  = sel_b ? gnt_b  : gnt_a;
  assign obs_done = sel_b ? done_b : done_a;
  assign obs_led  = sel_b ? led_b  : led_a;
  assign obs_busy = sel_b ? busy_b : busy_a;

  always #5 sys_clk = ~sys_clk;

  rgb_led_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP_A), .BLINK_HALF(BLINK)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req_a), .req_color(col_a),
    .gnt(gnt_a), .done(done_a), .busy(busy_a), .led(led_a)
  );

  rgb_led_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .BLINK_HALF(BLINK)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req_b), .req_color(col_b),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .led(led_b)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] bit_of(input int w);
    return 3'(32'd1 << w);
  endfunction

  function automatic logic [2:0] color_of(input logic [8:0] c, input int w);
    return c[3*w +: 3];
  endfunction

  // Round robin: first requester set, searching from the one after the last winner.
  function automatic int model_pick(input logic [2:0] r, input int last);
    int idx;
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // LED level k cycles into IDLE (k = 0 is the entry cycle).
  function automatic logic [2:0] idle_led(input int k);
    return (BLINK_ON && ((k / BLINK) % 2 == 1)) ? 3'b000 : 3'b111;
  endfunction

  // Called at the negedge of SHOW cycle 1; returns at the first IDLE cycle.
  task automatic run_display(input int w, input logic [2:0] col, input int gap);
    for (int c = 1; c <= HOLD; c++) begin
      chk("show_gnt", obs_gnt, (c == 1) ? bit_of(w) : 3'b000);
      chk("show_led", obs_led, ~col);
      chk("show_busy", {2'b00, obs_busy}, 3'b001);
      chk("show_done", obs_done, 3'b000);
      @(negedge sys_clk);
    end
    for (int c = 1; c <= gap; c++) begin
      chk("gap_done", obs_done, (c == 1) ? bit_of(w) : 3'b000);
      chk("gap_gnt", obs_gnt, 3'b000);
      chk("gap_led", obs_led, 3'b111);
      chk("gap_busy", {2'b00, obs_busy}, 3'b001);
      @(negedge sys_clk);
    end
    idle_k = 0;
    chk("idle_done", obs_done, (gap == 0) ? bit_of(w) : 3'b000);
    chk("idle_gnt", obs_gnt, 3'b000);
    chk("idle_led", obs_led, 3'b111);
    chk("idle_busy", {2'b00, obs_busy}, 3'b000);
  endtask

  // Called at an IDLE negedge: present r, let the DUT arbitrate, check the display.
  task automatic grant(input logic [2:0] r, input bit held, input int gap);
    int         w;
    logic [2:0] col;
    if (sel_b) req_b = r; else req_a = r;
    w   = model_pick(r, last_w[sel_b]);
    col = color_of(sel_b ? col_b : col_a, w);
    @(negedge sys_clk);
    last_w[sel_b] = w;
    // Winner drops its request; the others keep theirs. Colours may change freely.
    if (!held) begin
      if (sel_b) req_b = req_b & ~bit_of(w); else req_a = req_a & ~bit_of(w);
    end
    if (sel_b) col_b = 9'($urandom); else col_a = 9'($urandom);
    run_display(w, col, gap);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      idle_k++;
      chk("idle_led", obs_led, idle_led(idle_k));
      chk("idle_busy", {2'b00, obs_busy}, 3'b000);
      chk("idle_gnt", obs_gnt, 3'b000);
      chk("idle_done", obs_done, 3'b000);
    end
  endtask

  initial begin
    logic [2:0] r;
    int         w;
    logic [2:0] col;

    sys_rst_n = 1'b1;
    req_a = 3'b000; req_b = 3'b000;
    col_a = 9'd0;   col_b = 9'd0;
    last_w[0] = 2; last_w[1] = 2;
    idle_k = 0;
    #2 sys_rst_n = 1'b0;

    // Reset values on both instances.
    repeat (2) @(negedge sys_clk);
    chk("rst_led_a", led_a, 3'b111);
    chk("rst_busy_a", {2'b00, busy_a}, 3'b000);
    chk("rst_gnt_a", gnt_a, 3'b000);
    chk("rst_done_a", done_a, 3'b000);
    chk("rst_led_b", led_b, 3'b111);
    chk("rst_busy_b", {2'b00, busy_b}, 3'b000);
    sys_rst_n = 1'b1;
    idle_k = 0;
    idle_cycles(20);

    // Single request, red channel.
    col_a = 9'b000_000_001;
    grant(3'b001, 1'b0, GAP_A);
    idle_cycles(1);

    // All three requests held; requester 1 shows black.
    col_a = {3'($urandom_range(1, 7)), 3'b000, 3'($urandom_range(1, 7))};
    repeat (4) grant(3'b111, 1'b1, GAP_A);
    req_a = 3'b000;
    idle_cycles(2);

    // Random request mixes with random idle spacing.
    for (int i = 0; i < 16; i++) begin
      col_a = 9'($urandom);
      r = req_a | 3'($urandom_range(1, 7));
      grant(r, 1'b0, GAP_A);
      if (req_a == 3'b000) idle_cycles($urandom_range(0, 4));
    end
    for (int i = 0; i < 3; i++) begin
      if (req_a != 3'b000) grant(req_a, 1'b0, GAP_A);
    end
    idle_cycles(1);

    // No-gap instance: back-to-back displays with one off cycle between them.
    sel_b = 1'b1;
    col_b = {3'b011, 3'b101, 3'b110};
    grant(3'b010, 1'b1, 0);
    grant(3'b010, 1'b1, 0);
    req_b = 3'b000;
    idle_cycles(2);
    sel_b = 1'b0;

    // Reset during SHOW cycle 2: abort with no done pulse.
    col_a = {3'b001, 3'b010, 3'b100};
    req_a = 3'b010;
    w   = model_pick(req_a, last_w[0]);
    col = color_of(col_a, w);
    @(negedge sys_clk);
    chk("abort_gnt", gnt_a, bit_of(w));
    req_a = 3'b000;
    @(negedge sys_clk);
    chk("abort_led", led_a, ~col);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_rst_led", led_a, 3'b111);
    chk("abort_rst_busy", {2'b00, busy_a}, 3'b000);
    chk("abort_rst_done", done_a, 3'b000);
    @(negedge sys_clk);
    chk("abort_hold_done", done_a, 3'b000);
    chk("abort_hold_led", led_a, 3'b111);
    sys_rst_n = 1'b1;
    last_w[0] = 2; last_w[1] = 2;
    idle_k = 0;
    idle_cycles(3);
    // Pointer restarts at requester 0, so 3'b110 goes to requester 1.
    grant(3'b110, 1'b0, GAP_A);
    grant(req_a, 1'b0, GAP_A);

    // Request arriving part-way through IDLE.
    idle_cycles(4);
    col_a = 9'($urandom);
    grant(3'b100, 1'b0, GAP_A);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
